// File: rtl/wb_stage_exc.sv
// Write-back stage with precise exception/ertn handling and a post-flush drain window.
// Optional debug trace ports are compiled in with `define WB_DEBUG_TRACE_EN.
module wb_stage_exc #(
  parameter int                  EX_NUM    = 4,
  parameter logic [6*EX_NUM-1:0] EX_ECODES = {6'h0B, 6'h0C, 6'h09, 6'h08},
  parameter int                  DRAIN_CYC = 1,
  parameter int                  CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ws_allowin,
  input  logic                  ms_to_ws_valid,
  input  logic [160+EX_NUM-1:0] ms_to_ws_bus,
  output logic [38:0]           ws_to_rf_bus,
  output logic                  csr_re,
  output logic [13:0]           csr_num,
  input  logic [31:0]           csr_rvalue,
  output logic                  csr_we,
  output logic [31:0]           csr_wmask,
  output logic [31:0]           csr_wvalue,
  output logic                  wb_ex,
  output logic [5:0]            wb_ecode,
  output logic [8:0]            wb_esubcode,
  output logic                  ertn_flush,
  output logic [31:0]           wb_pc,
  input  logic [31:0]           ex_entry,
  input  logic [31:0]           era,
  output logic                  ws_flush_pipe,
  output logic [31:0]           ws_flush_target,
  output logic [CNT_W-1:0]      inst_retired
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [31:0]           debug_wb_pc,
  output logic [3:0]            debug_wb_rf_wen,
  output logic [4:0]            debug_wb_rf_wnum,
  output logic [31:0]           debug_wb_rf_wdata
`endif
);

  typedef struct packed {
    logic [EX_NUM-1:0] ex_vec;
    logic [8:0]        esubcode;
    logic              ertn;
    logic              csr_re;
    logic              csr_we;
    logic [13:0]       csr_num;
    logic [31:0]       csr_wmask;
    logic [31:0]       csr_wvalue;
    logic              gr_we;
    logic [4:0]        dest;
    logic [31:0]       result;
    logic [31:0]       pc;
  } ms_bus_t;

  typedef enum logic {S_RUN, S_DRAIN} state_e;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYC - 1);

  state_e          state_q, state_d;
  logic [3:0]      drain_q, drain_d;
  logic            ws_valid_q, ws_valid_d;
  ms_bus_t         bus_q;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic            ws_ready_go;
  logic            ws_live;
  logic            ex_any;
  logic [5:0]      ecode_sel;
  logic            rf_we;
  logic [31:0]     rf_wdata;
  logic            retire;

  assign ws_ready_go = 1'b1;

  // An instruction that slipped into WS during the flush cycle sits there while
  // draining; gating on RUN keeps it from having any architectural effect.
  assign ws_live = ws_valid_q && (state_q == S_RUN);
  assign ex_any  = |bus_q.ex_vec;

  // Lowest-numbered pending source wins: scan downward so the last hit is the lowest.
  always_comb begin
    ecode_sel = 6'h00;
    for (int i = EX_NUM - 1; i >= 0; i--) begin
      if (bus_q.ex_vec[i]) ecode_sel = EX_ECODES[6*i +: 6];
    end
  end

  assign wb_ex       = ws_live && ex_any;
  assign ertn_flush  = ws_live && bus_q.ertn && !ex_any;
  assign wb_ecode    = ex_any ? ecode_sel : 6'h00;
  assign wb_esubcode = ex_any ? bus_q.esubcode : 9'h000;
  assign wb_pc       = bus_q.pc;

  assign ws_flush_pipe   = wb_ex || ertn_flush;
  assign ws_flush_target = wb_ex ? ex_entry : era;

  assign rf_we        = ws_live && (bus_q.gr_we || bus_q.csr_re) && !ex_any;
  assign rf_wdata     = bus_q.csr_re ? csr_rvalue : bus_q.result;
  assign ws_to_rf_bus = {ws_live && bus_q.csr_re, rf_we, bus_q.dest, rf_wdata};

  assign csr_re     = ws_live && (bus_q.csr_re || bus_q.ertn);
  assign csr_we     = ws_live && bus_q.csr_we && !ex_any;
  assign csr_num    = bus_q.csr_num;
  assign csr_wmask  = bus_q.csr_wmask;
  assign csr_wvalue = bus_q.csr_wvalue;

  assign retire       = ws_live && !ex_any;
  assign retired_d    = retire ? retired_q + CNT_W'(1) : retired_q;
  assign inst_retired = retired_q;

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    ws_allowin = !ws_valid_q || ws_ready_go;
    ws_valid_d = ws_valid_q;
    case (state_q)
      S_RUN: begin
        if (ws_allowin) ws_valid_d = ms_to_ws_valid;
        if (ws_flush_pipe) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_INIT;
        end
      end
      S_DRAIN: begin
        ws_allowin = 1'b1;
        ws_valid_d = 1'b0;
        if (drain_q == 4'd0) state_d = S_RUN;
        else                 drain_d = drain_q - 4'd1;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RUN;
      drain_q    <= 4'd0;
      ws_valid_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      ws_valid_q <= ws_valid_d;
      retired_q  <= retired_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ms_to_ws_valid && ws_allowin) bus_q <= ms_bus_t'(ms_to_ws_bus);
  end

`ifdef WB_DEBUG_TRACE_EN
  assign debug_wb_pc       = bus_q.pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = bus_q.dest;
  assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule
